regfile_ext: RTL and testbench

REGFILE_EXT -- requirements
Module: regfile_ext

---
 rtl/regfile_ext.sv | 192 +++++++++++++++++++
 tb/tb_regfile_ext.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ext.sv
// Extended register file: eight GPRs, six segment registers, IP with shadow,
// flags with shadow, CX count support and optional read-after-write forwarding.
module regfile_ext #(
    parameter int          DW     = 16,
    parameter int          FLW    = 9,
    parameter logic [15:0] RST_CS = 16'hf000,
    parameter logic [15:0] RST_IP = 16'hfff0,
    parameter bit          BYPASS = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     addr_a,
    input  logic [3:0]     addr_b,
    input  logic [3:0]     addr_c,
    input  logic           a_byte,
    input  logic           b_byte,
    input  logic           c_byte,
    output logic [DW-1:0]  a,
    output logic [DW-1:0]  b,
    output logic [DW-1:0]  c,
    input  logic [1:0]     s_sel,
    output logic [15:0]    s,
    output logic [15:0]    cs,
    output logic [15:0]    ip,
    input  logic           wr,
    input  logic [3:0]     addr_d,
    input  logic [1:0]     size,
    input  logic [DW-1:0]  d,
    input  logic           wrhi,
    input  logic [DW-1:0]  d_hi,
    input  logic           cx_dec,
    input  logic           cx32,
    output logic           cx_zero,
    output logic           cx_one,
    input  logic           wrfl,
    input  logic [FLW-1:0] iflags,
    output logic [FLW-1:0] flags,
    input  logic           snap,
    input  logic           restore
);

    typedef logic [7:0][DW-1:0] gpr_t;
    typedef logic [7:0][15:0]   seg_t;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_WORD  = 2'b01;
    localparam logic [1:0] SZ_DWORD = 2'b10;

    localparam logic [2:0] CX_IDX = 3'd1;
    localparam logic [2:0] DX_IDX = 3'd2;
    localparam logic [2:0] CS_IDX = 3'd1;
    localparam logic [2:0] IPS_IDX = 3'd6;
    localparam logic [2:0] IP_IDX = 3'd7;

    // gpr holds addresses 0-7; seg holds addresses 8-15 (ES..GS, IP shadow, IP)
    gpr_t           gpr, gpr_w, gpr_n, gpr_rd;
    seg_t           seg, seg_w, seg_n, seg_rd;
    logic [FLW-1:0] flags_sh, flags_n, flags_sh_n;
    logic [1:0]     wsz;
    logic           cx_hit;

    function automatic logic [DW-1:0] sext8(input logic signed [7:0] v);
        return {{(DW-8){v[7]}}, v};
    endfunction

    // A dword request collapses to a word when the GPRs are only 16 bits wide
    function automatic logic [1:0] eff_size(input logic [1:0] sz);
        if (sz == SZ_BYTE)
            return SZ_BYTE;
        if (sz == SZ_DWORD && DW > 16)
            return SZ_DWORD;
        return SZ_WORD;
    endfunction

    function automatic logic [DW-1:0] merge_gpr(input logic [DW-1:0] old,
                                                input logic [DW-1:0] wd,
                                                input logic [1:0]    sz,
                                                input logic          hi_byte);
        logic [DW-1:0] r;
        r = old;
        case (sz)
            SZ_BYTE: begin
                if (hi_byte)
                    r[15:8] = wd[7:0];
                else
                    r[7:0] = wd[7:0];
            end
            SZ_DWORD: r = wd;
            default:  r[15:0] = wd[15:0];
        endcase
        return r;
    endfunction

    function automatic logic [DW-1:0] dec_count(input logic [DW-1:0] v,
                                                input logic          wide);
        logic [DW-1:0] r;
        r = v;
        if (wide)
            r = v - DW'(1);
        else
            r[15:0] = v[15:0] - 16'd1;
        return r;
    endfunction

    // Byte reads at 4-7 pick the high byte of register addr[1:0] (AH/CH/DH/BH)
    function automatic logic [DW-1:0] read_reg(input logic [3:0] ad,
                                               input logic       bsel,
                                               input gpr_t       g,
                                               input seg_t       sg);
        logic [DW-1:0] r;
        if (ad[3])
            r = DW'(sg[ad[2:0]]);
        else if (bsel)
            r = ad[2] ? sext8(g[{1'b0, ad[1:0]}][15:8]) : sext8(g[{1'b0, ad[1:0]}][7:0]);
        else
            r = g[ad[2:0]];
        return r;
    endfunction

    assign wsz    = eff_size(size);
    assign cx_hit = wr && !addr_d[3] &&
                    ((wsz == SZ_BYTE) ? (addr_d[1:0] == 2'd1) : (addr_d[2:0] == CX_IDX));

    // Register contents with only the wr/wrhi writes merged in
    always_comb begin
        gpr_w = gpr;
        seg_w = seg;
        if (wr) begin
            if (!addr_d[3]) begin
                if (wsz == SZ_BYTE)
                    gpr_w[{1'b0, addr_d[1:0]}] = merge_gpr(gpr[{1'b0, addr_d[1:0]}], d, wsz, addr_d[2]);
                else
                    gpr_w[addr_d[2:0]] = merge_gpr(gpr[addr_d[2:0]], d, wsz, 1'b0);
            end else if (!(addr_d[2:0] == IP_IDX && restore)) begin
                seg_w[addr_d[2:0]] = d[15:0];
            end
        end
        if (wrhi)
            gpr_w[DX_IDX] = d_hi;
    end

    // Full next state: count decrement, snapshot and rollback on top of the writes
    always_comb begin
        gpr_n      = gpr_w;
        seg_n      = seg_w;
        flags_n    = flags;
        flags_sh_n = flags_sh;
        if (cx_dec && !cx_hit)
            gpr_n[CX_IDX] = dec_count(gpr[CX_IDX], cx32);
        if (restore) begin
            seg_n[IP_IDX] = seg[IPS_IDX];
            flags_n       = flags_sh;
        end else begin
            if (wrfl)
                flags_n = iflags;
            if (snap) begin
                seg_n[IPS_IDX] = seg_w[IP_IDX];
                flags_sh_n     = flags_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpr            <= '0;
            seg            <= '0;
            seg[CS_IDX]    <= RST_CS;
            seg[IP_IDX]    <= RST_IP;
            flags          <= '0;
            flags_sh       <= '0;
        end else begin
            gpr            <= gpr_n;
            seg            <= seg_n;
            flags          <= flags_n;
            flags_sh       <= flags_sh_n;
        end
    end

    assign gpr_rd = BYPASS ? gpr_w : gpr;
    assign seg_rd = BYPASS ? seg_w : seg;

    assign a  = read_reg(addr_a, a_byte, gpr_rd, seg_rd);
    assign b  = read_reg(addr_b, b_byte, gpr_rd, seg_rd);
    assign c  = read_reg(addr_c, c_byte, gpr_rd, seg_rd);
    assign s  = seg[{1'b0, s_sel}];
    assign cs = seg[CS_IDX];
    assign ip = seg[IP_IDX];

    assign cx_zero = cx32 ? (gpr[CX_IDX] == '0)     : (gpr[CX_IDX][15:0] == 16'h0000);
    assign cx_one  = cx32 ? (gpr[CX_IDX] == DW'(1)) : (gpr[CX_IDX][15:0] == 16'h0001);

endmodule

// File: tb/tb_regfile_ext.sv
// Bench for regfile_ext: a 32-bit non-forwarding instance plus a forwarding
// twin driven by the same stimulus.
module tb_regfile_ext;

    localparam int DW  = 32;
    localparam int FLW = 9;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     addr_a = '0, addr_b = '0, addr_c = '0;
    logic           a_byte = 1'b0, b_byte = 1'b0, c_byte = 1'b0;
    logic [1:0]     s_sel = '0;
    logic           wr = 1'b0, wrhi = 1'b0, cx_dec = 1'b0, cx32 = 1'b0;
    logic [3:0]     addr_d = '0;
    logic [1:0]     size = '0;
    logic [DW-1:0]  d = '0, d_hi = '0;
    logic           wrfl = 1'b0, snap = 1'b0, restore = 1'b0;
    logic [FLW-1:0] iflags = '0;

    logic [DW-1:0]  a, b, c, a_y, b_y, c_y;
    logic [15:0]    s, cs, ip, s_y, cs_y, ip_y;
    logic           cx_zero, cx_one, cxz_y, cx1_y;
    logic [FLW-1:0] flags, flags_y;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [3:0]  ad;
        logic [1:0]  sz;
        logic [31:0] wd;
        logic [3:0]  ra;
        logic        rb;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t        vecs[NV];
    logic [31:0] sb[$];

    regfile_ext #(.DW(DW), .FLW(FLW), .BYPASS(1'b0)) u_dut (
        .clk(clk), .rst(rst),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
        .a_byte(a_byte), .b_byte(b_byte), .c_byte(c_byte),
        .a(a), .b(b), .c(c), .s_sel(s_sel), .s(s), .cs(cs), .ip(ip),
        .wr(wr), .addr_d(addr_d), .size(size), .d(d), .wrhi(wrhi), .d_hi(d_hi),
        .cx_dec(cx_dec), .cx32(cx32), .cx_zero(cx_zero), .cx_one(cx_one),
        .wrfl(wrfl), .iflags(iflags), .flags(flags), .snap(snap), .restore(restore)
    );

    regfile_ext #(.DW(DW), .FLW(FLW), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
        .a_byte(a_byte), .b_byte(b_byte), .c_byte(c_byte),
        .a(a_y), .b(b_y), .c(c_y), .s_sel(s_sel), .s(s_y), .cs(cs_y), .ip(ip_y),
        .wr(wr), .addr_d(addr_d), .size(size), .d(d), .wrhi(wrhi), .d_hi(d_hi),
        .cx_dec(cx_dec), .cx32(cx32), .cx_zero(cxz_y), .cx_one(cx1_y),
        .wrfl(wrfl), .iflags(iflags), .flags(flags_y), .snap(snap), .restore(restore)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst = 1'b0; wr = 1'b0; wrhi = 1'b0; cx_dec = 1'b0;
        wrfl = 1'b0; snap = 1'b0; restore = 1'b0;
    endtask

    task automatic set_wr(input logic [3:0] ad, input logic [1:0] sz, input logic [31:0] val);
        wr = 1'b1; addr_d = ad; size = sz; d = val;
    endtask

    task automatic rd(input logic [3:0] ad, input logic bsel,
                      output logic [31:0] v0, output logic [31:0] v1);
        addr_a = ad; a_byte = bsel;
        #1;
        v0 = a; v1 = a_y;
    endtask

    initial begin
        logic [31:0] v0, v1, exp;

        vecs[0]  = '{1'b1, 4'd0,  2'b10, 32'h12345678, 4'd0,  1'b0, 32'h12345678};
        vecs[1]  = '{1'b1, 4'd4,  2'b00, 32'h0000009A, 4'd0,  1'b0, 32'h12349A78};
        vecs[2]  = '{1'b0, 4'd0,  2'b00, 32'h00000000, 4'd4,  1'b1, 32'hFFFFFF9A};
        vecs[3]  = '{1'b1, 4'd0,  2'b00, 32'hFFFFFF05, 4'd0,  1'b0, 32'h12349A05};
        vecs[4]  = '{1'b1, 4'd3,  2'b10, 32'hAABBCCDD, 4'd3,  1'b0, 32'hAABBCCDD};
        vecs[5]  = '{1'b1, 4'd3,  2'b01, 32'h55551234, 4'd3,  1'b0, 32'hAABB1234};
        vecs[6]  = '{1'b1, 4'd10, 2'b10, 32'hFFFF7777, 4'd10, 1'b0, 32'h00007777};
        vecs[7]  = '{1'b1, 4'd8,  2'b00, 32'h00004321, 4'd8,  1'b0, 32'h00004321};
        vecs[8]  = '{1'b0, 4'd0,  2'b00, 32'h00000000, 4'd8,  1'b1, 32'h00004321};
        vecs[9]  = '{1'b0, 4'd0,  2'b00, 32'h00000000, 4'd7,  1'b1, 32'h00000012};
        vecs[10] = '{1'b1, 4'd6,  2'b00, 32'h00000080, 4'd2,  1'b0, 32'h00008000};
        vecs[11] = '{1'b0, 4'd0,  2'b00, 32'h00000000, 4'd6,  1'b1, 32'hFFFFFF80};
        vecs[12] = '{1'b0, 4'd0,  2'b00, 32'h00000000, 4'd9,  1'b0, 32'h0000F000};
        vecs[13] = '{1'b0, 4'd0,  2'b00, 32'h00000000, 4'd15, 1'b0, 32'h0000FFF0};
        vecs[14] = '{1'b1, 4'd5,  2'b01, 32'h0000CAFE, 4'd5,  1'b0, 32'h0000CAFE};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        addr_b = 4'd0; addr_c = 4'd9;
        rd(4'd0, 1'b0, v0, v1);
        check("rst_a", v0, 32'h0);
        check("rst_c_cs", c, 32'h0000F000);
        check("rst_cs", 32'(cs), 32'h0000F000);
        check("rst_ip", 32'(ip), 32'h0000FFF0);
        check("rst_cx_zero", 32'(cx_zero), 32'd1);
        check("rst_cx_one", 32'(cx_one), 32'd0);
        check("rst_flags", 32'(flags), 32'h0);

        // Table: write, then read back through port a after the edge
        for (int i = 0; i < NV; i++) begin
            wr = vecs[i].wr; addr_d = vecs[i].ad; size = vecs[i].sz; d = vecs[i].wd;
            step();
            addr_a = vecs[i].ra; a_byte = vecs[i].rb;
            sb.push_back(vecs[i].exp);
            @(negedge clk);
            exp = sb.pop_front();
            check($sformatf("vec%0d", i), a, exp);
        end

        // CX count run
        set_wr(4'd1, 2'b10, 32'hABCD0001);
        step();
        check("cx1_one", 32'(cx_one), 32'd1);
        check("cx1_zero", 32'(cx_zero), 32'd0);
        cx_dec = 1'b1;
        step();
        rd(4'd1, 1'b0, v0, v1);
        check("cx_dec_zero", 32'(cx_zero), 32'd1);
        check("cx_dec_one", 32'(cx_one), 32'd0);
        check("cx_dec_val", v0, 32'hABCD0000);
        cx_dec = 1'b1;
        step();
        rd(4'd1, 1'b0, v0, v1);
        check("cx_wrap16", v0, 32'hABCDFFFF);
        check("cx_wrap16_zero", 32'(cx_zero), 32'd0);
        set_wr(4'd1, 2'b10, 32'h00000000);
        cx32 = 1'b1;
        step();
        check("cx32_zero", 32'(cx_zero), 32'd1);
        cx_dec = 1'b1;
        step();
        rd(4'd1, 1'b0, v0, v1);
        check("cx32_wrap", v0, 32'hFFFFFFFF);
        cx32 = 1'b0;
        #1;
        check("cx16_view", 32'(cx_zero), 32'd0);

        // Write priority: wrhi over wr on DX, wr over cx_dec on CX
        set_wr(4'd2, 2'b01, 32'h00001111);
        wrhi = 1'b1; d_hi = 32'h00002222;
        step();
        rd(4'd2, 1'b0, v0, v1);
        check("dx_wrhi_wins", v0, 32'h00002222);
        set_wr(4'd1, 2'b01, 32'h00000005);
        cx_dec = 1'b1;
        step();
        rd(4'd1, 1'b0, v0, v1);
        check("cx_wr_wins", v0, 32'hFFFF0005);
        set_wr(4'd5, 2'b00, 32'h00000007);
        cx_dec = 1'b1;
        step();
        rd(4'd1, 1'b0, v0, v1);
        check("ch_wr_wins", v0, 32'hFFFF0705);
        rd(4'd5, 1'b0, v0, v1);
        check("bp_untouched", v0, 32'h0000CAFE);
        cx_dec = 1'b1;
        step();
        rd(4'd1, 1'b0, v0, v1);
        check("cx_dec_upper_kept", v0, 32'hFFFF0704);

        // Snapshot / rollback of IP and flags
        set_wr(4'd15, 2'b01, 32'h00000100);
        step();
        check("ip_0100", 32'(ip), 32'h00000100);
        snap = 1'b1; wrfl = 1'b1; iflags = 9'h0A5;
        step();
        rd(4'd14, 1'b0, v0, v1);
        check("snap_flags", 32'(flags), 32'h000000A5);
        check("snap_ipsh", v0, 32'h00000100);
        set_wr(4'd15, 2'b01, 32'h00000200);
        wrfl = 1'b1; iflags = 9'h1FF;
        step();
        check("ip_0200", 32'(ip), 32'h00000200);
        check("flags_1ff", 32'(flags), 32'h000001FF);
        set_wr(4'd15, 2'b01, 32'h00000300);
        restore = 1'b1; wrfl = 1'b1; iflags = 9'h033;
        step();
        check("restore_ip", 32'(ip), 32'h00000100);
        check("restore_flags", 32'(flags), 32'h000000A5);
        set_wr(4'd15, 2'b01, 32'h00000400);
        snap = 1'b1;
        step();
        rd(4'd14, 1'b0, v0, v1);
        check("snap_wr_ip", 32'(ip), 32'h00000400);
        check("snap_wr_ipsh", v0, 32'h00000400);
        set_wr(4'd15, 2'b01, 32'h00000600);
        step();
        snap = 1'b1; restore = 1'b1; wrfl = 1'b1; iflags = 9'h111;
        step();
        rd(4'd14, 1'b0, v0, v1);
        check("snap_restore_ip", 32'(ip), 32'h00000400);
        check("snap_restore_ipsh", v0, 32'h00000400);
        check("snap_restore_flags", 32'(flags), 32'h000000A5);

        // Segment read port
        s_sel = 2'd0; #1;
        check("s_es", 32'(s), 32'h00004321);
        s_sel = 2'd1; #1;
        check("s_cs", 32'(s), 32'h0000F000);
        s_sel = 2'd2; #1;
        check("s_ss", 32'(s), 32'h00007777);

        // Same-cycle read of a register being written
        set_wr(4'd0, 2'b10, 32'h0000BEEF);
        rd(4'd0, 1'b0, v0, v1);
        check("nobyp_old_ax", v0, 32'h12349A05);
        check("byp_new_ax", v1, 32'h0000BEEF);
        step();
        rd(4'd0, 1'b0, v0, v1);
        check("ax_beef", v0, 32'h0000BEEF);
        wrhi = 1'b1; d_hi = 32'hCAFEBABE;
        rd(4'd2, 1'b0, v0, v1);
        check("nobyp_old_dx", v0, 32'h00002222);
        check("byp_wrhi_dx", v1, 32'hCAFEBABE);
        step();
        set_wr(4'd4, 2'b00, 32'h000000F1);
        rd(4'd4, 1'b1, v0, v1);
        check("nobyp_old_ah", v0, 32'hFFFFFFBE);
        check("byp_new_ah", v1, 32'hFFFFFFF1);
        step();

        // Reset in the middle of a decrement run discards the same-cycle writes
        cx_dec = 1'b1;
        step();
        rd(4'd1, 1'b0, v0, v1);
        check("run_cx", v0, 32'hFFFF0703);
        cx_dec = 1'b1; rst = 1'b1; wrhi = 1'b1; wrfl = 1'b1; iflags = 9'h1FF;
        set_wr(4'd0, 2'b10, 32'h12345678);
        step();
        rd(4'd0, 1'b0, v0, v1);
        check("mid_rst_ax", v0, 32'h0);
        check("mid_rst_ax_byp", v1, 32'h0);
        rd(4'd1, 1'b0, v0, v1);
        check("mid_rst_cx", v0, 32'h0);
        rd(4'd2, 1'b0, v0, v1);
        check("mid_rst_dx", v0, 32'h0);
        check("mid_rst_cx_zero", 32'(cx_zero), 32'd1);
        check("mid_rst_cs", 32'(cs), 32'h0000F000);
        check("mid_rst_ip", 32'(ip), 32'h0000FFF0);
        check("mid_rst_flags", 32'(flags), 32'h0);
        addr_b = 4'd14; addr_c = 4'd10; s_sel = 2'd1;
        #1;
        check("mid_rst_ipsh", b, 32'h0);
        check("mid_rst_ss", c, 32'h0);
        check("byp_rst_b", b_y, 32'h0);
        check("byp_rst_c", c_y, 32'h0);
        check("byp_rst_s", 32'(s_y), 32'h0000F000);
        check("byp_rst_cs", 32'(cs_y), 32'h0000F000);
        check("byp_rst_ip", 32'(ip_y), 32'h0000FFF0);
        check("byp_rst_cxz", 32'(cxz_y), 32'd1);
        check("byp_rst_cx1", 32'(cx1_y), 32'd0);
        check("byp_rst_flags", 32'(flags_y), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
